// File: rtl/perceptron_train_ctrl_if.sv
// Control/handshake bundle between the perceptron training controller
// and its environment (sample source, host and datapath strobes).
interface perceptron_train_ctrl_if #(
    parameter int unsigned NUM_IN  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned EPOCH_W = 8,
    parameter int unsigned SEL_W   = $clog2(NUM_IN + 1)
);
    // Host configuration and sample source
    logic               start;
    logic               mode;
    logic [CNT_W-1:0]   n_samples;
    logic [EPOCH_W-1:0] max_epochs;
    logic               data_valid;
    logic               data_ready;
    logic               eq_flag;

    // Datapath strobes
    logic               init_w;
    logic               ld_x;
    logic               ld_t;
    logic               ld_yin;
    logic               ld_w;
    logic [SEL_W-1:0]   w_sel;

    // Status
    logic               epoch_restart;
    logic               busy;
    logic               done;
    logic               converged;
    logic               timeout;
    logic [EPOCH_W-1:0] epoch_cnt;

    // Controller side
    modport master (
        input  start, mode, n_samples, max_epochs, data_valid, eq_flag,
        output data_ready, init_w, ld_x, ld_t, ld_yin, ld_w, w_sel,
        output epoch_restart, busy, done, converged, timeout, epoch_cnt
    );

    // Environment side
    modport slave (
        output start, mode, n_samples, max_epochs, data_valid, eq_flag,
        input  data_ready, init_w, ld_x, ld_t, ld_yin, ld_w, w_sel,
        input  epoch_restart, busy, done, converged, timeout, epoch_cnt
    );
endinterface

// File: rtl/perceptron_train_ctrl.sv
// Training-sequence controller for the perceptron datapath: fetches samples
// over a valid/ready handshake, sequences per-weight updates, tracks epochs
// and reports convergence or epoch-limit timeout.
module perceptron_train_ctrl #(
    parameter int unsigned NUM_IN  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned EPOCH_W = 8,
    parameter int unsigned SEL_W   = $clog2(NUM_IN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    perceptron_train_ctrl_if.master ctrl_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_COMPUTE,
        S_CHECK,
        S_UPDATE,
        S_EPOCH_END,
        S_DONE
    } state_t;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IN);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   n_samples_q, n_samples_d;
    logic [EPOCH_W-1:0] max_epochs_q, max_epochs_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic               err_seen_q, err_seen_d;
    logic [SEL_W-1:0]   w_sel_q, w_sel_d;
    logic [EPOCH_W-1:0] epoch_cnt_q, epoch_cnt_d;
    logic               converged_q, converged_d;
    logic               timeout_q, timeout_d;

    logic               last_sample_c;
    logic [EPOCH_W-1:0] epoch_inc_c;
    logic               limit_hit_c;
    logic               advance_c;

    logic data_ready_c, init_w_c, ld_x_c, ld_t_c, ld_yin_c, ld_w_c;
    logic epoch_restart_c, busy_c, done_c;

    // Epoch bookkeeping helpers; n_samples is never 0 outside INIT so the
    // decrement cannot wrap, and the epoch count saturates at all-ones.
    assign last_sample_c = (sample_cnt_q == (n_samples_q - CNT_W'(1)));
    assign epoch_inc_c   = (&epoch_cnt_q) ? epoch_cnt_q : (epoch_cnt_q + EPOCH_W'(1));
    assign limit_hit_c   = (max_epochs_q != '0) && (epoch_inc_c == max_epochs_q);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            n_samples_q  <= '0;
            max_epochs_q <= '0;
            sample_cnt_q <= '0;
            err_seen_q   <= 1'b0;
            w_sel_q      <= '0;
            epoch_cnt_q  <= '0;
            converged_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            n_samples_q  <= n_samples_d;
            max_epochs_q <= max_epochs_d;
            sample_cnt_q <= sample_cnt_d;
            err_seen_q   <= err_seen_d;
            w_sel_q      <= w_sel_d;
            epoch_cnt_q  <= epoch_cnt_d;
            converged_q  <= converged_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        n_samples_d     = n_samples_q;
        max_epochs_d    = max_epochs_q;
        sample_cnt_d    = sample_cnt_q;
        err_seen_d      = err_seen_q;
        w_sel_d         = w_sel_q;
        epoch_cnt_d     = epoch_cnt_q;
        converged_d     = converged_q;
        timeout_d       = timeout_q;
        advance_c       = 1'b0;
        data_ready_c    = 1'b0;
        init_w_c        = 1'b0;
        ld_x_c          = 1'b0;
        ld_t_c          = 1'b0;
        ld_yin_c        = 1'b0;
        ld_w_c          = 1'b0;
        epoch_restart_c = 1'b0;
        done_c          = 1'b0;
        busy_c          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (ctrl_if.start) begin
                    mode_d       = ctrl_if.mode;
                    n_samples_d  = ctrl_if.n_samples;
                    max_epochs_d = ctrl_if.max_epochs;
                    converged_d  = 1'b0;
                    timeout_d    = 1'b0;
                    epoch_cnt_d  = '0;
                    state_d      = S_INIT;
                end
            end
            S_INIT: begin
                init_w_c     = 1'b1;
                sample_cnt_d = '0;
                err_seen_d   = 1'b0;
                if (n_samples_q == '0) begin
                    converged_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                data_ready_c = 1'b1;
                if (ctrl_if.data_valid) begin
                    ld_x_c  = 1'b1;
                    ld_t_c  = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                ld_yin_c = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (!ctrl_if.eq_flag) begin
                    err_seen_d = 1'b1;
                end
                if (mode_q || !ctrl_if.eq_flag) begin
                    w_sel_d = '0;
                    state_d = S_UPDATE;
                end else begin
                    advance_c = 1'b1;
                end
            end
            S_UPDATE: begin
                ld_w_c = 1'b1;
                if (w_sel_q == SEL_LAST) begin
                    w_sel_d   = '0;
                    advance_c = 1'b1;
                end else begin
                    w_sel_d = w_sel_q + SEL_W'(1);
                end
            end
            S_EPOCH_END: begin
                if (!err_seen_q) begin
                    converged_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    epoch_cnt_d = epoch_inc_c;
                    if (limit_hit_c) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        epoch_restart_c = 1'b1;
                        sample_cnt_d    = '0;
                        err_seen_d      = 1'b0;
                        state_d         = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared sample-advance step after CHECK or the last weight write
        if (advance_c) begin
            if (last_sample_c) begin
                state_d = S_EPOCH_END;
            end else begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
                state_d      = S_FETCH;
            end
        end
    end

    // Drive the interface
    assign ctrl_if.data_ready    = data_ready_c;
    assign ctrl_if.init_w        = init_w_c;
    assign ctrl_if.ld_x          = ld_x_c;
    assign ctrl_if.ld_t          = ld_t_c;
    assign ctrl_if.ld_yin        = ld_yin_c;
    assign ctrl_if.ld_w          = ld_w_c;
    assign ctrl_if.w_sel         = w_sel_q;
    assign ctrl_if.epoch_restart = epoch_restart_c;
    assign ctrl_if.busy          = busy_c;
    assign ctrl_if.done          = done_c;
    assign ctrl_if.converged     = converged_q;
    assign ctrl_if.timeout       = timeout_q;
    assign ctrl_if.epoch_cnt     = epoch_cnt_q;

endmodule

// File: doc/perceptron_train_ctrl.md
Name: perceptron_train_ctrl

Overview:
Parametrised training-sequence controller for the perceptron datapath. It generalises the fixed two-input controller in three ways: NUM_IN weight channels updated one per cycle, a valid/ready sample handshake, and a selectable update mode. It also adds an epoch limit with timeout. It drives the load and init strobes of the weight, bias, input and target registers and decides convergence from the datapath's eq_flag.

Parameters:
NUM_IN, 2, inputs per sample (number of weight channels); must be at least 1
CNT_W, 16, width of the sample counter and of n_samples
EPOCH_W, 8, width of the epoch counter and of max_epochs
SEL_W, $clog2(NUM_IN+1), width of w_sel; index NUM_IN selects the bias

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin training; sampled only in IDLE
mode  in  1  0 = update only on error; 1 = update every sample; latched at start
n_samples  in  CNT_W  samples per epoch; latched at start
max_epochs  in  EPOCH_W  epoch limit; 0 = unlimited; latched at start
data_valid  in  1  sample source has x/t available
data_ready  out  1  controller accepts a sample
eq_flag  in  1  datapath: prediction equals target (update delta is zero)
init_w  out  1  clear all weights and the bias
ld_x  out  1  load the input vector
ld_t  out  1  load the target
ld_yin  out  1  load the net-input register
ld_w  out  1  write weight/bias selected by w_sel
w_sel  out  SEL_W  weight index 0..NUM_IN-1; NUM_IN = bias
epoch_restart  out  1  one-cycle pulse telling the source to rewind to sample 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
converged  out  1  training ended with an error-free epoch
timeout  out  1  training ended at the max_epochs limit
epoch_cnt  out  EPOCH_W  epochs completed with errors

Behaviour:
- Reset (async, any state): state = IDLE; counters, flags, converged, timeout and epoch_cnt = 0; all strobes, data_ready, w_sel, busy and done = 0.
- States: IDLE, INIT, FETCH, COMPUTE, CHECK, UPDATE, EPOCH_END, DONE.
- IDLE:
  - start=1: latch mode, n_samples and max_epochs; clear converged, timeout and epoch_cnt; go to INIT.
  - start in any other state is ignored.
- INIT (1 cycle):
  - init_w=1; sample_cnt=0; err_seen=0.
  - If n_samples==0, go to DONE with converged=1; otherwise go to FETCH.
- FETCH:
  - data_ready=1.
  - On data_valid&&data_ready: ld_x=ld_t=1 in the same cycle, then go to COMPUTE. Otherwise stay in FETCH.
  - data_ready is 0 in all other states.
- COMPUTE (1 cycle): ld_yin=1.
- CHECK (1 cycle): sample eq_flag.
  - eq_flag=0: set err_seen.
  - Go to UPDATE if mode==1 or eq_flag==0; otherwise go to the sample-advance step.
- UPDATE (exactly NUM_IN+1 cycles):
  - ld_w=1 every cycle; w_sel steps 0,1,...,NUM_IN.
  - After w_sel==NUM_IN, go to the sample-advance step.
  - w_sel = 0 outside UPDATE.
- Sample advance:
  - If sample_cnt==n_samples-1, go to EPOCH_END.
  - Otherwise sample_cnt++ and go to FETCH.
  - Comparison uses full CNT_W width; n_samples = 2^CNT_W-1 must work with no wrap.
- EPOCH_END (1 cycle):
  - err_seen=0: go to DONE with converged=1.
  - err_seen=1: epoch_cnt++.
    - If max_epochs!=0 and the new epoch_cnt==max_epochs, go to DONE with timeout=1.
    - Otherwise pulse epoch_restart, clear sample_cnt and err_seen, go to FETCH.
  - epoch_cnt saturates at all-ones when max_epochs==0 and keeps running epochs.
- DONE (1 cycle): done=1, then IDLE.
  - converged, timeout and epoch_cnt hold until the next accepted start.
  - converged and timeout are never both 1.
- Latency: a handshake in cycle k gives COMPUTE at k+1 and CHECK at k+2.
  - No update: next FETCH (or EPOCH_END) at k+3.
  - With update: ld_w in cycles k+3..k+3+NUM_IN, next FETCH at k+4+NUM_IN.
- data_valid is ignored outside FETCH. The source must hold the sample until it is accepted.

Test Plan:
- NUM_IN=2, mode=0, n_samples=4, eq_flag always 1 -> one epoch, 4 handshakes, no ld_w; done at EPOCH_END+1; converged=1, epoch_cnt=0.
- NUM_IN=3, mode=0, n_samples=2, eq_flag=0 in epoch 1 then 1 -> each erroneous sample gives 4 ld_w cycles with w_sel 0,1,2,3; one epoch_restart pulse; converged=1, epoch_cnt=1.
- mode=1, eq_flag=1 always, n_samples=3 -> ld_w burst after every sample (3 bursts); converged=1 after the first epoch.
- max_epochs=3, eq_flag=0 always -> epoch_restart pulsed twice; done with timeout=1, converged=0, epoch_cnt=3.
- n_samples=0 -> INIT, then DONE; no data_ready; converged=1; done 2 cycles after the start edge.
- data_valid held low 5 cycles in FETCH -> no ld_x, data_ready stays 1. Assert rst mid-UPDATE -> all outputs 0 immediately; a new start restarts from INIT.
